// File: rtl/cpu_dma.sv
// cpu_dma - multi-channel cycle-stealing DMA engine between the 6502 core
// and the system bus. It halts the CPU via cpu_ce, takes over the bus, and
// copies blocks from a 16-bit source to a fixed or incrementing destination.
// Channel 0 (highest priority) serves sprite OAM DMA ($4014 -> $2004).
//
// Optional feature macro: CPU_DMA_ALIGN_EN
//   defined   - an ALIGN dead cycle follows HALT when parity=1 (513/514 for OAM)
//   undefined - no ALIGN state; every transfer takes 1 + 2*N ce cycles
//
// Parameters:
//   CHANNELS  number of channels (1..4), index 0 has highest priority
//   LEN_W     length field width; len=0 means 2^LEN_W bytes
//   DST_INC   bit c=1: channel c destination increments per byte
//
// Ports:
//   clock, reset_n       system clock, synchronous active-low reset
//   ce                   CPU-rate enable; all state advances only when ce=1
//   cpu_A/D/R/W          CPU bus request (address, write data, strobes)
//   cpu_ce               enable to the CPU core
//   A/D/R/W              muxed bus to memory/PPU/APU
//   I                    bus read data, valid in the same ce cycle as A
//   req                  one-clock start pulse per channel
//   src/dst/len          per-channel descriptors, sampled on req
//   busy                 channel currently transferring
//   done                 one-clock pulse when a channel finishes
module cpu_dma #(
    parameter int                  CHANNELS = 2,
    parameter int                  LEN_W    = 8,
    parameter logic [CHANNELS-1:0] DST_INC  = '0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      ce,
    input  logic [15:0]               cpu_A,
    input  logic [7:0]                cpu_D,
    input  logic                      cpu_R,
    input  logic                      cpu_W,
    output logic                      cpu_ce,
    output logic [15:0]               A,
    output logic [7:0]                D,
    output logic                      R,
    output logic                      W,
    input  logic [7:0]                I,
    input  logic [CHANNELS-1:0]       req,
    input  logic [16*CHANNELS-1:0]    src,
    input  logic [16*CHANNELS-1:0]    dst,
    input  logic [LEN_W*CHANNELS-1:0] len,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
`ifdef CPU_DMA_ALIGN_EN
        ALIGN = 3'd2,
`endif
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t state, state_next;

    logic [15:0]      src_q [CHANNELS];
    logic [15:0]      dst_q [CHANNELS];
    logic [LEN_W-1:0] len_q [CHANNELS];

    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] accept;
    logic [CH_W-1:0]     ch;
    logic [CH_W-1:0]     gnt;
    logic [LEN_W-1:0]    idx;
    logic [7:0]          data;
    logic                grab;
    logic                last;
    logic [15:0]         rd_addr;
    logic [15:0]         wr_addr;

    // Arbitration: lowest pending index wins. Only write-free CPU cycles are
    // stolen, because a halted write would be lost.
    always_comb begin
        gnt = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (pending[c]) gnt = CH_W'(c);
        end
        grab = (state == IDLE) && ce && (|pending) && !cpu_W;
        // A channel being granted this clock is treated as busy so its
        // descriptor cannot change under the transfer that is starting.
        for (int c = 0; c < CHANNELS; c++) begin
            accept[c] = req[c] && !busy[c] && !(grab && (gnt == CH_W'(c)));
        end
    end

    // len=0 wraps to len-1 = all ones, i.e. 2^LEN_W bytes.
    assign last    = (idx == (len_q[ch] - LEN_W'(1)));
    assign rd_addr = src_q[ch] + 16'(idx);
    assign wr_addr = DST_INC[ch] ? (dst_q[ch] + 16'(idx)) : dst_q[ch];

`ifdef CPU_DMA_ALIGN_EN
    // Free-running CPU-cycle parity; decides whether an ALIGN cycle is needed.
    logic parity;

    always_ff @(posedge clock) begin
        if (!reset_n) parity <= 1'b0;
        else if (ce)  parity <= ~parity;
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        cpu_ce     = 1'b0;
        A          = cpu_A;
        D          = cpu_D;
        R          = 1'b0;
        W          = 1'b0;
        case (state)
            IDLE: begin
                // The grabbed CPU cycle is suppressed by dropping cpu_ce.
                cpu_ce = ce && !grab;
                R      = cpu_R;
                W      = cpu_W;
                if (grab) state_next = HALT;
            end
            HALT: begin
`ifdef CPU_DMA_ALIGN_EN
                if (ce) state_next = parity ? ALIGN : READ;
`else
                if (ce) state_next = READ;
`endif
            end
`ifdef CPU_DMA_ALIGN_EN
            ALIGN: begin
                if (ce) state_next = READ;
            end
`endif
            READ: begin
                A = rd_addr;
                D = data;
                R = 1'b1;
                if (ce) state_next = WRITE;
            end
            WRITE: begin
                A = wr_addr;
                D = data;
                W = 1'b1;
                if (ce) state_next = last ? IDLE : READ;
            end
            default: state_next = IDLE;
        endcase
    end

    // Descriptors are plain data: latched on an accepted request, no reset.
    always_ff @(posedge clock) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (accept[c]) begin
                src_q[c] <= src[16*c +: 16];
                dst_q[c] <= dst[16*c +: 16];
                len_q[c] <= len[LEN_W*c +: LEN_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending <= '0;
            busy    <= '0;
            done    <= '0;
            ch      <= '0;
            idx     <= '0;
            data    <= '0;
        end else begin
            done <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                if (accept[c]) pending[c] <= 1'b1;
            end
            if (grab) begin
                pending[gnt] <= 1'b0;
                busy[gnt]    <= 1'b1;
                ch           <= gnt;
                idx          <= '0;
            end
            if (ce && (state == READ)) data <= I;
            if (ce && (state == WRITE)) begin
                idx <= idx + LEN_W'(1);
                if (last) begin
                    busy[ch] <= 1'b0;
                    done[ch] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_dma.sv
module tb_cpu_dma;

    localparam int               CHANNELS = 2;
    localparam int               LEN_W    = 8;
    localparam logic [1:0]       DST_INC  = 2'b10;

    logic                      clock = 1'b0;
    logic                      reset_n;
    logic                      ce;
    logic [15:0]               cpu_A;
    logic [7:0]                cpu_D;
    logic                      cpu_R;
    logic                      cpu_W;
    logic                      cpu_ce;
    logic [15:0]               A;
    logic [7:0]                D;
    logic                      R;
    logic                      W;
    logic [7:0]                I;
    logic [CHANNELS-1:0]       req;
    logic [16*CHANNELS-1:0]    src;
    logic [16*CHANNELS-1:0]    dst;
    logic [LEN_W*CHANNELS-1:0] len;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS-1:0]       done;

    cpu_dma #(.CHANNELS(CHANNELS), .LEN_W(LEN_W), .DST_INC(DST_INC)) dut (
        .clock(clock), .reset_n(reset_n), .ce(ce),
        .cpu_A(cpu_A), .cpu_D(cpu_D), .cpu_R(cpu_R), .cpu_W(cpu_W),
        .cpu_ce(cpu_ce), .A(A), .D(D), .R(R), .W(W), .I(I),
        .req(req), .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Memory model: read data is a fixed function of the address.
    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    assign I = pat(A);

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t ev_q[$];
    int  n_q[$];
    int  ch_q[$];

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  cur_exp = 0;
    int  wr_cnt = 0;
    logic [CHANNELS-1:0] prev_busy = '0;
    bit  tb_par = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference CPU-cycle parity, used to predict the ALIGN cycle.
    always @(posedge clock) begin
        if (!reset_n) tb_par <= 1'b0;
        else if (ce)  tb_par <= ~tb_par;
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_busy = '0;
        end else begin
            if (busy != '0 && prev_busy == '0) begin
                if (n_q.size() == 0 || ch_q.size() == 0) begin
                    check("unexp_busy", 32'(busy), 32'd0);
                end else begin
                    check("busy_ch", 32'(busy), 32'(1) << ch_q[0]);
                    cur_exp = 1 + 2 * n_q.pop_front();
`ifdef CPU_DMA_ALIGN_EN
                    if (tb_par) cur_exp++;
`endif
                    cyc = 0;
                end
            end
            prev_busy = busy;
            if (ce && busy != '0) begin
                cyc++;
                if (R || W) begin
                    if (ev_q.size() == 0) begin
                        check("unexp_bus", 32'(A), 32'hFFFF_FFFF);
                    end else begin
                        ev_t e;
                        e = ev_q.pop_front();
                        check(e.wr ? "wr_addr" : "rd_addr", 32'(A), 32'(e.addr));
                        check("strobes", 32'({R, W}), 32'({~e.wr, e.wr}));
                        if (e.wr) begin
                            check("wr_data", 32'(D), 32'(e.data));
                            wr_cnt++;
                        end
                    end
                end
            end
            if (done != '0) begin
                if (ch_q.size() == 0) begin
                    check("unexp_done", 32'(done), 32'd0);
                end else begin
                    int c;
                    c = ch_q.pop_front();
                    check("done_ch", 32'(done), 32'(1) << c);
                    check("cycles", 32'(cyc), 32'(cur_exp));
                    if (ch_q.size() == 0) check("ce_return", 32'(cpu_ce), 32'(ce));
                end
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Load a descriptor and queue everything the transfer must produce.
    task automatic setup(input int c, input logic [15:0] s, input logic [15:0] d, input int l);
        int n;
        logic [15:0] ra, wa;
        src[16*c +: 16]       = s;
        dst[16*c +: 16]       = d;
        len[LEN_W*c +: LEN_W] = LEN_W'(l);
        n = (l == 0) ? (1 << LEN_W) : l;
        for (int k = 0; k < n; k++) begin
            ra = s + 16'(k);
            wa = DST_INC[c] ? (d + 16'(k)) : d;
            ev_q.push_back('{wr: 1'b0, addr: ra, data: 8'h00});
            ev_q.push_back('{wr: 1'b1, addr: wa, data: pat(ra)});
        end
        n_q.push_back(n);
        ch_q.push_back(c);
    endtask

    task automatic pulse(input logic [CHANNELS-1:0] m);
        req = m;
        tick();
        req = '0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((ch_q.size() != 0 || busy != '0) && n < budget) begin
            tick();
            n++;
        end
        check("wait_ok", 32'(n < budget), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        ce      = 1'b1;
        cpu_A   = 16'h8123;
        cpu_D   = 8'h77;
        cpu_R   = 1'b1;
        cpu_W   = 1'b0;
        req     = '0;
        src     = '0;
        dst     = '0;
        len     = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cpu_ce", 32'(cpu_ce), 32'd1);
        check("rst_pass_A", 32'(A), 32'h8123);
        check("rst_pass_RW", 32'({R, W}), 32'b10);
        reset_n = 1'b1;
        repeat (2) tick();

        // OAM copy, requested on both parity phases
        for (int t = 0; t < 2; t++) begin
            while (tb_par != t[0]) tick();
            setup(0, 16'h0200, 16'h2004, 0);
            pulse(2'b01);
            wait_done(2000);
            repeat (3) tick();
        end

        // CPU write cycles are never stolen
        setup(0, 16'h0600, 16'h2004, 2);
        cpu_W = 1'b1;
        cpu_R = 1'b0;
        cpu_A = 16'h2000;
        cpu_D = 8'hA5;
        pulse(2'b01);
        for (int k = 0; k < 3; k++) begin
            check("wr_pass_ce", 32'(cpu_ce), 32'd1);
            check("wr_pass", 32'({A, D, W}), 32'({16'h2000, 8'hA5, 1'b1}));
            check("wr_nobusy", 32'(busy), 32'd0);
            tick();
        end
        cpu_W = 1'b0;
        cpu_R = 1'b1;
        cpu_A = 16'h8123;
        #1;
        check("grab_ce", 32'(cpu_ce), 32'd0);
        wait_done(100);
        repeat (2) tick();

        // Simultaneous requests: ch0 first, ch1 with incrementing destination
        setup(0, 16'h0300, 16'h2004, 2);
        setup(1, 16'h0500, 16'h4000, 4);
        pulse(2'b11);
        wait_done(200);
        repeat (2) tick();

        // Source wrap, with a ce freeze in the middle
        setup(0, 16'hFFFE, 16'h2004, 3);
        pulse(2'b01);
        repeat (4) tick();
        ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("frz_cpu_ce", 32'(cpu_ce), 32'd0);
            check("frz_busy", 32'(busy), 32'd1);
        end
        ce = 1'b1;
        wait_done(100);
        repeat (2) tick();

        // Reset mid-transfer
        wr_cnt = 0;
        setup(0, 16'h0200, 16'h2004, 0);
        pulse(2'b01);
        begin
            int n = 0;
            while (wr_cnt < 10 && n < 100) begin
                tick();
                n++;
            end
            check("abort_reach", 32'(wr_cnt >= 10), 32'd1);
        end
        reset_n = 1'b0;
        ev_q.delete();
        n_q.delete();
        ch_q.delete();
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_cpu_ce", 32'(cpu_ce), 32'(ce));
        check("abort_pass", 32'({A, R}), 32'({16'h8123, 1'b1}));
        reset_n = 1'b1;
        repeat (20) tick();
        check("abort_idle", 32'({busy, done}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
